// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter sequencer: operation select
// and the strobe priority encoder.
package pc_pkg;

    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_INC  = 3'd1,
        OP_BR   = 3'd2,
        OP_LOAD = 3'd3,
        OP_CALL = 3'd4,
        OP_RET  = 3'd5
    } op_e;

    // clr is handled by the caller; among the rest ret wins, inc loses.
    function automatic op_e op_select(
        input logic ret,
        input logic call,
        input logic load,
        input logic br,
        input logic inc
    );
        op_e op;
        op = OP_NONE;
        if (ret)       op = OP_RET;
        else if (call) op = OP_CALL;
        else if (load) op = OP_LOAD;
        else if (br)   op = OP_BR;
        else if (inc)  op = OP_INC;
        return op;
    endfunction

endpackage

// File: rtl/pc_ret_stack.sv
// DEPTH x AW return-address LIFO. Push at full and pop at empty are ignored;
// the storage array itself is not reset.
module pc_ret_stack #(
    parameter int AW    = 6,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         clr,
    input  logic                         push,
    input  logic                         pop,
    input  logic [AW-1:0]                push_data,
    output logic [AW-1:0]                top,
    output logic [$clog2(DEPTH+1)-1:0]   sp,
    output logic                         full,
    output logic                         empty
);

    localparam int SPW = $clog2(DEPTH+1);

    logic [AW-1:0] mem [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign full    = (sp == SPW'(DEPTH));
    assign empty   = (sp == '0);
    assign do_push = push && !full && !clr;
    assign do_pop  = pop && !empty && !clr;

    always_ff @(posedge clk) begin
        if (clr) begin
            sp <= '0;
        end else if (do_push) begin
            sp <= sp + SPW'(1);
        end else if (do_pop) begin
            sp <= sp - SPW'(1);
        end
    end

    // Entry selection by comparison keeps the sp width independent of the array index width.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (do_push && sp == SPW'(i)) begin
                mem[i] <= push_data;
            end
        end
    end

    always_comb begin
        top = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (sp == SPW'(i + 1)) begin
                top = mem[i];
            end
        end
    end

endmodule

// File: rtl/pc_seq.sv
// Program-counter sequencer: prioritised inc/branch/jump/call/return with a
// hardware return stack and sticky overflow/underflow flags.
module pc_seq
    import pc_pkg::*;
#(
    parameter int            AW      = 6,
    parameter int            DEPTH   = 4,
    parameter logic [AW-1:0] RST_VAL = '0
) (
    input  logic                         clk,
    input  logic                         clr,
    input  logic [AW-1:0]                data_in,
    input  logic [AW-1:0]                offset,
    input  logic                         load,
    input  logic                         inc,
    input  logic                         br,
    input  logic                         call,
    input  logic                         ret,
    output logic [AW-1:0]                data_out,
    output logic [$clog2(DEPTH+1)-1:0]   sp,
    output logic                         full,
    output logic                         empty,
    output logic                         err_ovf,
    output logic                         err_unf
);

    op_e           op;
    logic          push;
    logic          pop;
    logic [AW-1:0] top;
    logic [AW-1:0] ret_addr;
    logic [AW-1:0] pc_next;

    always_comb op = op_select(ret, call, load, br, inc);

    assign ret_addr = data_out + AW'(1);
    assign push     = !clr && (op == OP_CALL) && !full;
    assign pop      = !clr && (op == OP_RET) && !empty;

    pc_ret_stack #(
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_stack (
        .clk       (clk),
        .clr       (clr),
        .push      (push),
        .pop       (pop),
        .push_data (ret_addr),
        .top       (top),
        .sp        (sp),
        .full      (full),
        .empty     (empty)
    );

    // A rejected call or return leaves the PC where it was.
    always_comb begin
        pc_next = data_out;
        unique case (op)
            OP_INC:  pc_next = data_out + AW'(1);
            OP_BR:   pc_next = data_out + offset;
            OP_LOAD: pc_next = data_in;
            OP_CALL: if (!full)  pc_next = data_in;
            OP_RET:  if (!empty) pc_next = top;
            default: pc_next = data_out;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            data_out <= RST_VAL;
            err_ovf  <= 1'b0;
            err_unf  <= 1'b0;
        end else begin
            data_out <= pc_next;
            if (op == OP_CALL && full)  err_ovf <= 1'b1;
            if (op == OP_RET && empty)  err_unf <= 1'b1;
        end
    end

endmodule
